// File: rtl/scan_sequencer.sv
// -----------------------------------------------------------------------------
// scan_sequencer
//   Walks a (row, column) address space in row-major order by sequencing two
//   external up-counters (3-bit row, 4-bit column). A start pulse clears both
//   counters, then one request per point is offered over valid/ready. The
//   counters advance only on accepted requests; done pulses after the last one.
//
// Ports
//   clk        in  : single clock, rising edge
//   Reset      in  : synchronous, active-high
//   start      in  : begin a scan (sampled in IDLE only)
//   abort      in  : cancel the scan in progress
//   row_count  in  : current row counter value
//   col_count  in  : current column counter value
//   req_ready  in  : downstream accepts the request
//   row_inc    out : row counter Inc pin
//   row_clr    out : row counter Reset pin (flop output)
//   col_inc    out : column counter Inc pin
//   col_clr    out : column counter Reset pin (flop output)
//   req_valid  out : request presented
//   req_row    out : request row (= row_count)
//   req_col    out : request column (= col_count)
//   req_last   out : presented request is the final point
//   busy       out : state is not IDLE
//   done       out : one-cycle completion pulse
// -----------------------------------------------------------------------------
module scan_sequencer #(
   parameter int unsigned ROW_LAST = 7,
   parameter int unsigned COL_LAST = 15
) (
   input  logic       clk,
   input  logic       Reset,
   input  logic       start,
   input  logic       abort,
   input  logic [2:0] row_count,
   input  logic [3:0] col_count,
   input  logic       req_ready,
   output logic       row_inc,
   output logic       row_clr,
   output logic       col_inc,
   output logic       col_clr,
   output logic       req_valid,
   output logic [2:0] req_row,
   output logic [3:0] req_col,
   output logic       req_last,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      CLEAR = 3'd1,
      ISSUE = 3'd2,
      WRAP  = 3'd3,
      DONE  = 3'd4
   } state_e;

   localparam logic [2:0] ROW_LAST_C = 3'(ROW_LAST);
   localparam logic [3:0] COL_LAST_C = 4'(COL_LAST);

   state_e state_q, state_d;
   logic   row_clr_q, row_clr_d;
   logic   col_clr_q, col_clr_d;
   logic   done_q, done_d;
   logic   busy_q, busy_d;

   logic   handshake;
   logic   row_at_last;
   logic   col_at_last;

   assign row_at_last = (row_count == ROW_LAST_C);
   assign col_at_last = (col_count == COL_LAST_C);

   // Handshake and increments are combinational so the counters move at the
   // very edge that accepts the request; abort kills them in the same cycle.
   assign req_valid = (state_q == ISSUE) && !abort;
   assign handshake = req_valid && req_ready;
   assign col_inc   = handshake && !col_at_last;
   assign row_inc   = (state_q == WRAP) && !abort;
   assign req_last  = (state_q == ISSUE) && row_at_last && col_at_last;
   assign req_row   = row_count;
   assign req_col   = col_count;

   // The clear pins feed asynchronous counter resets, so they are decoded
   // from the next state and registered rather than decoded from state_q.
   assign row_clr = row_clr_q;
   assign col_clr = col_clr_q;
   assign done    = done_q;
   assign busy    = busy_q;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path can
      // leave it unassigned and infer a latch.
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = CLEAR;
         CLEAR:   state_d = abort ? IDLE : ISSUE;
         ISSUE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (handshake && col_at_last) begin
               state_d = row_at_last ? DONE : WRAP;
            end
         end
         WRAP:    state_d = abort ? IDLE : ISSUE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      row_clr_d = (state_d == CLEAR);
      col_clr_d = (state_d == CLEAR) || (state_d == WRAP);
      done_d    = (state_d == DONE);
      busy_d    = (state_d != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (Reset) begin
         state_q   <= IDLE;
         row_clr_q <= 1'b0;
         col_clr_q <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         row_clr_q <= row_clr_d;
         col_clr_q <= col_clr_d;
         done_q    <= done_d;
         busy_q    <= busy_d;
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// -----------------------------------------------------------------------------
// tb_scan_sequencer
//   Directed bench for scan_sequencer. Instance A uses default parameters and
//   is checked against a queue of expected (row, col, last) points; instance B
//   uses ROW_LAST=1, COL_LAST=0 for the small-space timing case. Both drive
//   behavioural counter models with asynchronous clear pins.
// -----------------------------------------------------------------------------
module tb_scan_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       Reset;
   int         cyc = 0;
   int         t0  = 0;
   int         checks = 0;
   int         errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- instance A (default parameters) ----------------
   logic       start_a, abort_a, ready_a;
   logic [2:0] row_cnt_a;
   logic [3:0] col_cnt_a;
   logic       row_inc_a, row_clr_a, col_inc_a, col_clr_a;
   logic       valid_a, last_a, busy_a, done_a;
   logic [2:0] req_row_a;
   logic [3:0] req_col_a;

   scan_sequencer u_dut_a (
      .clk       (clk),
      .Reset     (Reset),
      .start     (start_a),
      .abort     (abort_a),
      .row_count (row_cnt_a),
      .col_count (col_cnt_a),
      .req_ready (ready_a),
      .row_inc   (row_inc_a),
      .row_clr   (row_clr_a),
      .col_inc   (col_inc_a),
      .col_clr   (col_clr_a),
      .req_valid (valid_a),
      .req_row   (req_row_a),
      .req_col   (req_col_a),
      .req_last  (last_a),
      .busy      (busy_a),
      .done      (done_a)
   );

   always @(posedge clk or posedge row_clr_a)
      if (row_clr_a) row_cnt_a <= '0;
      else if (row_inc_a) row_cnt_a <= row_cnt_a + 3'd1;

   always @(posedge clk or posedge col_clr_a)
      if (col_clr_a) col_cnt_a <= '0;
      else if (col_inc_a) col_cnt_a <= col_cnt_a + 4'd1;

   // ---------------- instance B (ROW_LAST=1, COL_LAST=0) ----------------
   logic       start_b, abort_b, ready_b;
   logic [2:0] row_cnt_b;
   logic [3:0] col_cnt_b;
   logic       row_inc_b, row_clr_b, col_inc_b, col_clr_b;
   logic       valid_b, last_b, busy_b, done_b;
   logic [2:0] req_row_b;
   logic [3:0] req_col_b;

   scan_sequencer #(.ROW_LAST(1), .COL_LAST(0)) u_dut_b (
      .clk       (clk),
      .Reset     (Reset),
      .start     (start_b),
      .abort     (abort_b),
      .row_count (row_cnt_b),
      .col_count (col_cnt_b),
      .req_ready (ready_b),
      .row_inc   (row_inc_b),
      .row_clr   (row_clr_b),
      .col_inc   (col_inc_b),
      .col_clr   (col_clr_b),
      .req_valid (valid_b),
      .req_row   (req_row_b),
      .req_col   (req_col_b),
      .req_last  (last_b),
      .busy      (busy_b),
      .done      (done_b)
   );

   always @(posedge clk or posedge row_clr_b)
      if (row_clr_b) row_cnt_b <= '0;
      else if (row_inc_b) row_cnt_b <= row_cnt_b + 3'd1;

   always @(posedge clk or posedge col_clr_b)
      if (col_clr_b) col_cnt_b <= '0;
      else if (col_inc_b) col_cnt_b <= col_cnt_b + 4'd1;

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: {row, col, last} for each point still to be accepted.
   logic [7:0] expect_q[$];
   int         done_cnt = 0;
   int         done_cyc = -1;

   always @(negedge clk) begin
      if (Reset === 1'b0 && valid_a === 1'b1 && ready_a === 1'b1) begin
         if (expect_q.size() == 0) begin
            check("hs_unexpected", 32'd1, 32'd0);
         end else begin
            logic [7:0] e;
            e = expect_q.pop_front();
            check("hs_point", {24'd0, req_row_a, req_col_a, last_a}, {24'd0, e});
         end
      end
      if (done_a === 1'b1) begin
         done_cnt++;
         done_cyc = cyc - t0;
      end
   end

   function automatic logic [7:0] outs_a();
      return {row_inc_a, row_clr_a, col_inc_a, col_clr_a,
              valid_a, last_a, busy_a, done_a};
   endfunction

   function automatic logic [7:0] outs_b();
      return {row_inc_b, row_clr_b, col_inc_b, col_clr_b,
              valid_b, last_b, busy_b, done_b};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
      #1;
   endtask

   task automatic goto_cycle(input int n);
      while (cyc - t0 < n) step();
   endtask

   // Loads the full expected sequence, pulses start in cycle 0, and checks
   // the clear pulse in cycle 1.
   task automatic start_scan();
      expect_q.delete();
      for (int r = 0; r < 8; r++)
         for (int c = 0; c < 16; c++)
            expect_q.push_back({3'(r), 4'(c), (r == 7 && c == 15)});
      start_a = 1'b1;
      t0      = cyc;
      step();
      start_a = 1'b0;
      sample();
      check("clear_pulse", {29'd0, row_clr_a, col_clr_a, busy_a}, 32'h7);
   endtask

   task automatic run_to_done(input string tag, input int exp_cyc);
      int n0;
      int k;
      n0 = done_cnt;
      k  = 0;
      while (done_cnt == n0 && k < 400) begin
         sample();
         k++;
      end
      check({tag, "_done_seen"}, done_cnt - n0, 1);
      check({tag, "_done_cycle"}, done_cyc, exp_cyc);
      sample();
      check({tag, "_busy_after"}, {31'd0, busy_a}, 32'd0);
      check({tag, "_done_once"}, done_cnt - n0, 1);
      check({tag, "_queue_empty"}, expect_q.size(), 0);
   endtask

   initial begin
      int n_done;
      Reset   = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; ready_a = 1'b1;
      start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b1;
      repeat (2) step();
      sample();
      check("reset_outs_a", {24'd0, outs_a()}, 32'd0);
      check("reset_outs_b", {24'd0, outs_b()}, 32'd0);
      step();
      Reset = 1'b0;
      step();

      // Small space on instance B: (0,0), WRAP, (1,0), DONE.
      start_b = 1'b1;
      t0      = cyc;
      step();
      start_b = 1'b0;
      sample();
      check("b_c1_clr", {30'd0, row_clr_b, col_clr_b}, 32'h3);
      sample();
      check("b_c2_req", {24'd0, valid_b, req_row_b, req_col_b}, {24'd0, 1'b1, 3'd0, 4'd0});
      sample();
      check("b_c3_wrap", {29'd0, row_inc_b, col_clr_b, valid_b}, {29'd0, 3'b110});
      sample();
      check("b_c4_req", {23'd0, valid_b, req_row_b, req_col_b, last_b},
            {23'd0, 1'b1, 3'd1, 4'd0, 1'b1});
      sample();
      check("b_c5_done", {31'd0, done_b}, 32'd1);
      sample();
      check("b_c6_idle", {24'd0, outs_b()}, 32'd0);
      step();

      // Full scan with ready held high.
      start_scan();
      run_to_done("full", 137);
      step();

      // Back-pressure for three cycles while (2,5) is presented (cycle 41).
      start_scan();
      goto_cycle(41);
      ready_a = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sample();
         check("stall_hold", {23'd0, valid_a, req_row_a, req_col_a, col_inc_a},
               {23'd0, 1'b1, 3'd2, 4'd5, 1'b0});
         step();
      end
      ready_a = 1'b1;
      run_to_done("stall", 140);
      step();

      // Abort while (3,4) is presented (cycle 57).
      start_scan();
      goto_cycle(57);
      abort_a = 1'b1;
      n_done  = done_cnt;
      sample();
      check("abort_no_hs", {29'd0, valid_a, col_inc_a, row_inc_a}, 32'd0);
      check("abort_accepted", expect_q.size(), 76);
      step();
      abort_a = 1'b0;
      sample();
      check("abort_idle", {24'd0, outs_a()}, 32'd0);
      check("abort_no_done", done_cnt - n_done, 0);
      step();
      start_scan();
      run_to_done("restart", 137);
      step();

      // Ignored start mid-scan, then Reset mid-scan.
      start_scan();
      goto_cycle(30);
      start_a = 1'b1;
      step();
      start_a = 1'b0;
      sample();
      check("restart_ignored", {29'd0, row_clr_a, col_clr_a, busy_a}, 32'h1);
      goto_cycle(60);
      Reset  = 1'b1;
      n_done = done_cnt;
      step();
      Reset = 1'b0;
      sample();
      check("midreset_outs", {24'd0, outs_a()}, 32'd0);
      check("midreset_addr", {25'd0, req_row_a, req_col_a}, {25'd0, row_cnt_a, col_cnt_a});
      check("midreset_no_done", done_cnt - n_done, 0);
      step();
      start_scan();
      run_to_done("post_reset", 137);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
